wb_snoop_responder: RTL

Per-data-cache snoop responder: the answering end of the snoop bus driven by the Wishbone snoop arbiter. When the arbiter raises a snoop read, the block latches the snoop address and requests the cache's tag/data RAM port. It performs a direct-mapped tag compare and returns ack, hit and data, holding them until the arbiter drops the request. One instance sits beside each data cache, and its snoop outputs form one slice of the arbiter's `num_dbus`-wide snoop inputs.

---
 rtl/wb_snoop_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_snoop_responder.sv
// Snoop responder for one data cache. Accepts a level snoop read from the
// Wishbone snoop arbiter and latches the address. It then arbitrates for the
// cache tag/data RAM port and does a direct-mapped tag compare. ack/hit/data
// are held until the arbiter drops the request.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   snoop_adr_i             snoop byte address (latched on acceptance)
//   snoop_type_i            snoop read request level
//   snoop_ack_o/_hit_o/_dat_o  registered response, held while request stays high
//   ram_req_o, ram_gnt_i    RAM port request / grant
//   ram_urgent_o            request has waited >= wait_limit cycles
//   ram_idx_o, ram_word_o   set index / word-in-line from latched address
//   tag_i, valid_i, dat_i   RAM read data, valid the cycle after grant
module wb_snoop_responder #(
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned index_bits  = 8,
  parameter int unsigned offset_bits = 2,
  parameter int unsigned wait_limit  = 8
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic [aw-1:0]                         snoop_adr_i,
  input  logic                                  snoop_type_i,
  output logic                                  snoop_ack_o,
  output logic                                  snoop_hit_o,
  output logic [dw-1:0]                         snoop_dat_o,
  output logic                                  ram_req_o,
  input  logic                                  ram_gnt_i,
  output logic                                  ram_urgent_o,
  output logic [index_bits-1:0]                 ram_idx_o,
  output logic [offset_bits-1:0]                ram_word_o,
  input  logic [aw-index_bits-offset_bits-3:0]  tag_i,
  input  logic                                  valid_i,
  input  logic [dw-1:0]                         dat_i
);

  localparam int unsigned TW     = aw - index_bits - offset_bits - 2;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned IDX_LO = offset_bits + 2;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    REQ    = 4'b0010,
    LOOKUP = 4'b0100,
    RESP   = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [aw-1:0]       adr_q, adr_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ack_q, ack_d;
  logic                hit_q, hit_d;
  logic [dw-1:0]       dat_q, dat_d;
  logic                req_q, req_d;
  logic                urgent_q, urgent_d;
  logic                tag_match_c;
  logic                unused_adr_lsb;

  assign tag_match_c    = (tag_i == adr_q[aw-1 -: TW]);
  assign unused_adr_lsb = ^adr_q[1:0];

  // State and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      wait_q   <= '0;
      ack_q    <= 1'b0;
      hit_q    <= 1'b0;
      dat_q    <= '0;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      wait_q   <= wait_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      dat_q    <= dat_d;
      req_q    <= req_d;
      urgent_q <= urgent_d;
    end
  end

  // Next-state and response logic
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wait_d  = wait_q;
    ack_d   = ack_q;
    hit_d   = hit_q;
    dat_d   = dat_q;

    unique case (state_q)
      IDLE: begin
        if (snoop_type_i) begin
          adr_d   = snoop_adr_i;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // Grant takes priority: the RAM has already sampled the address.
        if (ram_gnt_i) begin
          state_d = LOOKUP;
        end else if (!snoop_type_i) begin
          state_d = IDLE;
        end else if (wait_q < WAIT_W'(wait_limit)) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      LOOKUP: begin
        if (!snoop_type_i) begin
          state_d = IDLE;
        end else begin
          ack_d   = 1'b1;
          hit_d   = valid_i && tag_match_c;
          dat_d   = (valid_i && tag_match_c) ? dat_i : '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!snoop_type_i) begin
          ack_d   = 1'b0;
          hit_d   = 1'b0;
          dat_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        hit_d   = 1'b0;
        dat_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Request and urgency track the state being entered so both are registered.
    req_d    = (state_d == REQ);
    urgent_d = (state_d == REQ) && (wait_d >= WAIT_W'(wait_limit));
  end

  assign snoop_ack_o  = ack_q;
  assign snoop_hit_o  = hit_q;
  assign snoop_dat_o  = dat_q;
  assign ram_req_o    = req_q;
  assign ram_urgent_o = urgent_q;
  assign ram_idx_o    = adr_q[IDX_LO +: index_bits];
  assign ram_word_o   = adr_q[2 +: offset_bits];

endmodule
